bp_resolve_queue: RTL and testbench

- In-order queue that captures every prediction made by the next-PC predictor at fetch, together with its prediction metadata.
- Pops the oldest entry when the execute stage resolves the corresponding control-flow instruction.
- Compares the predicted next PC with the real one and drives the predictor's training and update inputs (update_en, npc_ex, hashes, kind_ex, choice_real, choice_pdch_ex, ret_pc_ex, mis_pdc).
- Flushes wrong-path entries and issues a fetch redirect on a misprediction.

---
 rtl/bp_resolve_queue.sv | 124 ++++++++++++
 tb/tb_bp_resolve_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue
//   In-order queue of next-PC predictions made at fetch. Each resolve from
//   execute pops the oldest entry, compares the predicted and actual next PC,
//   and drives the predictor training interface one cycle later. A wrong
//   prediction flushes every younger (wrong-path) entry and requests a fetch
//   redirect.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   enq_*                 prediction capture from fetch (enq_ready = !full)
//   res_*                 resolution of the oldest instruction from execute
//   update_en .. mis_pdc  registered predictor training outputs
//   redirect_valid/pc     one-cycle fetch restart request
//   count                 current occupancy
module bp_resolve_queue #(
  parameter  int DEPTH      = 8,
  parameter  int ADDR_WIDTH = 30,
  parameter  int gh_width   = 14,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [ADDR_WIDTH-1:0] enq_npc_pdc,
  input  logic [2:0]            enq_kind,
  input  logic                  enq_choice_btb_ras,
  input  logic [1:0]            enq_choice_pdch,
  input  logic [gh_width-1:0]   enq_pc_hashed,
  input  logic [gh_width-1:0]   enq_pc_bh_hashed,
  input  logic                  res_valid,
  input  logic [ADDR_WIDTH-1:0] res_npc_real,
  input  logic [2:0]            res_kind,
  input  logic [ADDR_WIDTH-1:0] res_ret_pc,
  output logic                  update_en,
  output logic [ADDR_WIDTH-1:0] npc_ex,
  output logic [gh_width-1:0]   pc_ex_hashed,
  output logic [gh_width-1:0]   pc_ex_bh_hashed,
  output logic [2:0]            kind_ex,
  output logic                  choice_real,
  output logic [1:0]            choice_pdch_ex,
  output logic [ADDR_WIDTH-1:0] ret_pc_ex,
  output logic                  mis_pdc,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [PW-1:0]         count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] npc_pdc;
    logic                  choice_btb_ras;
    logic [1:0]            choice_pdch;
    logic [gh_width-1:0]   pc_hashed;
    logic [gh_width-1:0]   pc_bh_hashed;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_e;
  logic [PW-1:0] head, tail, head_nxt;
  logic          empty, full, pop, mis, push;

  // Training uses the kind resolved in execute, so the predicted kind is
  // not kept.
  logic unused_kind;
  assign unused_kind = ^enq_kind;

  assign empty     = (head == tail);
  assign full      = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign count     = tail - head;
  assign enq_ready = !full;

  assign head_e   = mem[head[AW-1:0]];
  assign head_nxt = head + PW'(1);
  assign pop      = res_valid && !empty;
  assign mis      = pop && (head_e.npc_pdc != res_npc_real);
  // A mispredict makes any same-cycle fetch wrong-path, so it is dropped.
  assign push     = enq_valid && !full && !mis;

  // Contents need no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[tail[AW-1:0]] <= '{enq_npc_pdc, enq_choice_btb_ras,
                                     enq_choice_pdch, enq_pc_hashed,
                                     enq_pc_bh_hashed};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      update_en       <= 1'b0;
      mis_pdc         <= 1'b0;
      redirect_valid  <= 1'b0;
      npc_ex          <= '0;
      pc_ex_hashed    <= '0;
      pc_ex_bh_hashed <= '0;
      kind_ex         <= '0;
      choice_real     <= 1'b0;
      choice_pdch_ex  <= '0;
      ret_pc_ex       <= '0;
      redirect_pc     <= '0;
    end else begin
      if (pop) head <= head_nxt;
      // Flush: everything younger than the popped entry is wrong-path.
      if (mis)       tail <= head_nxt;
      else if (push) tail <= tail + PW'(1);

      update_en      <= pop;
      mis_pdc        <= mis;
      redirect_valid <= mis;
      if (pop) begin
        npc_ex          <= res_npc_real;
        pc_ex_hashed    <= head_e.pc_hashed;
        pc_ex_bh_hashed <= head_e.pc_bh_hashed;
        kind_ex         <= res_kind;
        // A wrong RET target means the other selector would have been right.
        choice_real     <= head_e.choice_btb_ras ^ mis;
        choice_pdch_ex  <= head_e.choice_pdch;
        ret_pc_ex       <= res_ret_pc;
      end
      if (mis) redirect_pc <= res_npc_real;
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
module tb_bp_resolve_queue;
  localparam int DEPTH = 8, AWD = 30, GH = 14, PW = 4;

  logic            clk = 1'b0, rst;
  logic            enq_valid, enq_ready, enq_choice_btb_ras;
  logic [AWD-1:0]  enq_npc_pdc, res_npc_real, res_ret_pc;
  logic [2:0]      enq_kind, res_kind, kind_ex;
  logic [1:0]      enq_choice_pdch, choice_pdch_ex;
  logic [GH-1:0]   enq_pc_hashed, enq_pc_bh_hashed, pc_ex_hashed, pc_ex_bh_hashed;
  logic            res_valid, update_en, choice_real, mis_pdc, redirect_valid;
  logic [AWD-1:0]  npc_ex, ret_pc_ex, redirect_pc;
  logic [PW-1:0]   count;
  int              tests = 0, failed = 0;

  bp_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AWD), .gh_width(GH)) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_npc_pdc(enq_npc_pdc), .enq_kind(enq_kind),
    .enq_choice_btb_ras(enq_choice_btb_ras), .enq_choice_pdch(enq_choice_pdch),
    .enq_pc_hashed(enq_pc_hashed), .enq_pc_bh_hashed(enq_pc_bh_hashed),
    .res_valid(res_valid), .res_npc_real(res_npc_real), .res_kind(res_kind),
    .res_ret_pc(res_ret_pc), .update_en(update_en), .npc_ex(npc_ex),
    .pc_ex_hashed(pc_ex_hashed), .pc_ex_bh_hashed(pc_ex_bh_hashed),
    .kind_ex(kind_ex), .choice_real(choice_real), .choice_pdch_ex(choice_pdch_ex),
    .ret_pc_ex(ret_pc_ex), .mis_pdc(mis_pdc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .count(count));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_enq(input logic [AWD-1:0] npc, input logic [2:0] kind,
                         input logic br, input logic [1:0] pdch,
                         input logic [GH-1:0] h, input logic [GH-1:0] bh);
    enq_valid = 1'b1; enq_npc_pdc = npc; enq_kind = kind;
    enq_choice_btb_ras = br; enq_choice_pdch = pdch;
    enq_pc_hashed = h; enq_pc_bh_hashed = bh;
  endtask

  task automatic push(input logic [AWD-1:0] npc, input logic [2:0] kind,
                      input logic br, input logic [GH-1:0] h);
    set_enq(npc, kind, br, 2'd0, h, 14'h0);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic resolve(input logic [AWD-1:0] npc, input logic [2:0] kind);
    res_valid = 1'b1; res_npc_real = npc; res_kind = kind; res_ret_pc = '0;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enq_valid = 1'b0; res_valid = 1'b0;
    set_enq(30'h777, 3'd1, 1'b1, 2'd3, 14'h1, 14'h2);
    res_npc_real = '0; res_kind = '0; res_ret_pc = '0;

    // Reset with a push pending: nothing must be captured.
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_ready", enq_ready, 1);
    chk("rst_update_en", update_en, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_mis", mis_pdc, 0);
    chk("rst_npc_ex", npc_ex, 0);
    rst = 1'b0; enq_valid = 1'b0;
    tick();
    chk("rst_count_after", count, 0);

    // Correct prediction with full metadata.
    set_enq(30'h100, 3'd1, 1'b0, 2'd2, 14'h3A, 14'h15);
    tick(); enq_valid = 1'b0;
    chk("ok_count_push", count, 1);
    res_valid = 1'b1; res_npc_real = 30'h100; res_kind = 3'd1; res_ret_pc = 30'h55;
    tick(); res_valid = 1'b0;
    chk("ok_update_en", update_en, 1);
    chk("ok_mis", mis_pdc, 0);
    chk("ok_npc_ex", npc_ex, 30'h100);
    chk("ok_hashed", pc_ex_hashed, 14'h3A);
    chk("ok_bh_hashed", pc_ex_bh_hashed, 14'h15);
    chk("ok_pdch", choice_pdch_ex, 2);
    chk("ok_kind", kind_ex, 1);
    chk("ok_ret_pc", ret_pc_ex, 30'h55);
    chk("ok_choice_real", choice_real, 0);
    chk("ok_redirect", redirect_valid, 0);
    chk("ok_count", count, 0);
    tick();
    chk("idle_update_en", update_en, 0);
    chk("idle_npc_hold", npc_ex, 30'h100);

    // Misprediction flush with a simultaneous push.
    push(30'h10, 3'd1, 1'b0, 14'h1);
    push(30'h20, 3'd1, 1'b0, 14'h2);
    push(30'h30, 3'd1, 1'b0, 14'h3);
    push(30'h40, 3'd1, 1'b0, 14'h4);
    chk("mis_count_pre", count, 4);
    set_enq(30'h50, 3'd1, 1'b0, 2'd0, 14'h5, 14'h0);
    res_valid = 1'b1; res_npc_real = 30'h99; res_kind = 3'd1;
    tick(); enq_valid = 1'b0; res_valid = 1'b0;
    chk("mis_update_en", update_en, 1);
    chk("mis_mis", mis_pdc, 1);
    chk("mis_redirect", redirect_valid, 1);
    chk("mis_redirect_pc", redirect_pc, 30'h99);
    chk("mis_hashed", pc_ex_hashed, 14'h1);
    chk("mis_count", count, 0);
    tick();
    chk("mis_redirect_drop", redirect_valid, 0);
    chk("mis_mis_drop", mis_pdc, 0);
    chk("mis_count_hold", count, 0);
    push(30'h60, 3'd1, 1'b0, 14'h6);
    resolve(30'h60, 3'd1);
    chk("post_flush_mis", mis_pdc, 0);
    chk("post_flush_hashed", pc_ex_hashed, 14'h6);

    // Fill to capacity (pointers start mid-buffer, so this wraps).
    for (int i = 0; i < DEPTH; i++) push(30'h1000 + 30'(i * 4), 3'd1, 1'b0, 14'(i + 1));
    chk("full_count", count, DEPTH);
    chk("full_ready", enq_ready, 0);
    push(30'hDEAD, 3'd1, 1'b0, 14'h3FFF);
    chk("full_drop_count", count, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      resolve(30'h1000 + 30'(i * 4), 3'd1);
      chk($sformatf("fifo_mis_%0d", i), mis_pdc, 0);
      chk($sformatf("fifo_hashed_%0d", i), pc_ex_hashed, 14'(i + 1));
    end
    chk("fifo_count_end", count, 0);
    chk("fifo_ready_end", enq_ready, 1);

    // RET selector training.
    push(30'h200, 3'd4, 1'b1, 14'h7);
    resolve(30'h200, 3'd4);
    chk("ret_hit_choice", choice_real, 1);
    chk("ret_hit_mis", mis_pdc, 0);
    push(30'h200, 3'd4, 1'b1, 14'h7);
    resolve(30'h204, 3'd4);
    chk("ret_miss1_choice", choice_real, 0);
    chk("ret_miss1_mis", mis_pdc, 1);
    chk("ret_miss1_kind", kind_ex, 4);
    push(30'h200, 3'd4, 1'b0, 14'h7);
    resolve(30'h208, 3'd4);
    chk("ret_miss0_choice", choice_real, 1);
    chk("ret_miss0_redir_pc", redirect_pc, 30'h208);

    // Resolve on an empty queue is ignored.
    tick();
    resolve(30'h999, 3'd7);
    chk("empty_update_en", update_en, 0);
    chk("empty_mis", mis_pdc, 0);
    chk("empty_redirect", redirect_valid, 0);
    chk("empty_count", count, 0);
    chk("empty_npc_hold", npc_ex, 30'h208);

    // Concurrent push and correct resolve keeps occupancy.
    push(30'h300, 3'd1, 1'b0, 14'h11);
    push(30'h304, 3'd1, 1'b0, 14'h12);
    push(30'h308, 3'd1, 1'b0, 14'h13);
    set_enq(30'h30C, 3'd1, 1'b0, 2'd0, 14'h14, 14'h0);
    res_valid = 1'b1; res_npc_real = 30'h300; res_kind = 3'd1;
    tick(); enq_valid = 1'b0; res_valid = 1'b0;
    chk("conc_count", count, 3);
    chk("conc_update_en", update_en, 1);
    chk("conc_mis", mis_pdc, 0);
    resolve(30'h304, 3'd1); chk("conc_h1", pc_ex_hashed, 14'h12);
    resolve(30'h308, 3'd1); chk("conc_h2", pc_ex_hashed, 14'h13);
    resolve(30'h30C, 3'd1); chk("conc_h3", pc_ex_hashed, 14'h14);
    chk("conc_mis_last", mis_pdc, 0);
    chk("conc_count_end", count, 0);

    // Reset overrides an in-flight resolve.
    push(30'h400, 3'd1, 1'b0, 14'h21);
    rst = 1'b1; res_valid = 1'b1; res_npc_real = 30'h404;
    tick(); rst = 1'b0; res_valid = 1'b0;
    chk("rst_fl_update_en", update_en, 0);
    chk("rst_fl_redirect", redirect_valid, 0);
    chk("rst_fl_count", count, 0);
    chk("rst_fl_npc_ex", npc_ex, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
